// File: rtl/add16u_mon_pkg.sv
// Shared types and default widths for the approximate-adder error monitor.
package add16u_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mon_state_t;

   localparam int unsigned MON_W     = 16;
   localparam int unsigned MON_CNT_W = 32;
   localparam int unsigned MON_ACC_W = 48;

endpackage

// File: rtl/add16u_abs_err.sv
// Stage 1: exact W+1-bit sum of the operands and absolute difference to the
// approximate result, registered together with a valid bit.
module add16u_abs_err
   import add16u_mon_pkg::*;
#(
   parameter int unsigned W = MON_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         acc_valid,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W:0]   approx,
   output logic         err_valid,
   output logic [W:0]   err,
   output logic         err_nz
);

   logic [W:0] exact;
   logic [W:0] diff;

   always_comb begin
      exact = {1'b0, a} + {1'b0, b};
      diff  = (exact >= approx) ? (exact - approx) : (approx - exact);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_valid <= 1'b0;
         err       <= '0;
         err_nz    <= 1'b0;
      end else begin
         err_valid <= acc_valid;
         err       <= diff;
         err_nz    <= (diff != '0);
      end
   end

endmodule

// File: rtl/add16u_err_monitor.sv
// Run-length controlled error characterisation: FSM, sample counting and the
// stage-2 accumulators (saturating error sum, worst-case error, error count).
module add16u_err_monitor
   import add16u_mon_pkg::*;
#(
   parameter int unsigned W     = MON_W,
   parameter int unsigned CNT_W = MON_CNT_W,
   parameter int unsigned ACC_W = MON_ACC_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [W:0]       in_approx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [ACC_W-1:0] err_sum,
   output logic [W:0]       wce,
   output logic             ovf
);

   mon_state_t       state, state_nxt;
   logic [CNT_W-1:0] target;
   logic             accept;
   logic             last_accept;
   logic             start_idle;

   logic             s1_valid;
   logic [W:0]       s1_err;
   logic             s1_nz;
   logic [ACC_W:0]   sum_ext;
   logic             sat;

   assign in_ready    = (state == RUN);
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign accept      = in_valid && in_ready;
   assign last_accept = accept && ((sample_cnt + CNT_W'(1)) == target);
   assign start_idle  = start && (state == IDLE);

   add16u_abs_err #(.W(W)) u_abs_err (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc_valid (accept),
      .a         (in_a),
      .b         (in_b),
      .approx    (in_approx),
      .err_valid (s1_valid),
      .err       (s1_err),
      .err_nz    (s1_nz)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
         RUN:     if (last_accept) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         target <= '0;
      end else begin
         state <= state_nxt;
         if (start_idle) target <= num_samples;
      end
   end

   // One extra bit catches the carry out of the accumulator for saturation.
   always_comb begin
      sum_ext = (ACC_W+1)'(err_sum) + (ACC_W+1)'(s1_err);
      sat     = sum_ext[ACC_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         err_sum    <= '0;
         wce        <= '0;
         ovf        <= 1'b0;
      end else if (start_idle) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         err_sum    <= '0;
         wce        <= '0;
         ovf        <= 1'b0;
      end else begin
         if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
         if (s1_valid) begin
            err_sum <= sat ? '1 : sum_ext[ACC_W-1:0];
            if (sat) ovf <= 1'b1;
            if (s1_err > wce) wce <= s1_err;
            if (s1_nz) err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Self-checking bench: behavioural run model compared every cycle against a
// default-width instance and an 18-bit-accumulator instance sharing stimulus.
module tb_add16u_err_monitor;

   localparam logic [63:0] MAX48 = 64'h0000_FFFF_FFFF_FFFF;
   localparam logic [63:0] MAX18 = 64'h0000_0000_0003_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] num_samples = '0;
   logic        in_valid = 1'b0;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic [16:0] in_approx = '0;

   logic        in_ready, busy, done, ovf;
   logic [31:0] sample_cnt, err_cnt;
   logic [47:0] err_sum;
   logic [16:0] wce;

   logic        s_in_ready, s_busy, s_done, s_ovf;
   logic [31:0] s_sample_cnt, s_err_cnt;
   logic [17:0] s_err_sum;
   logic [16:0] s_wce;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   add16u_err_monitor dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_approx(in_approx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
      .err_cnt(err_cnt), .err_sum(err_sum), .wce(wce), .ovf(ovf)
   );

   add16u_err_monitor #(.ACC_W(18)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
      .in_approx(in_approx), .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt),
      .err_cnt(s_err_cnt), .err_sum(s_err_sum), .wce(s_wce), .ovf(s_ovf)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint unsigned abs_err(input logic [15:0] a, input logic [15:0] b,
                                               input logic [16:0] ap);
      longint unsigned ex, apx;
      ex  = longint'(a) + longint'(b);
      apx = longint'(ap);
      return (ex >= apx) ? ex - apx : apx - ex;
   endfunction

   // Behavioural model: a run timeline plus plain-integer accumulators.
   bit              m_ready, m_busy, m_done, m_drain, m_ovf, m_ovf_s, pend_v;
   longint unsigned m_target, m_scnt, m_ecnt, m_sum, m_sum_s, m_wce, pend_e;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready = 0; m_busy = 0; m_done = 0; m_drain = 0; m_ovf = 0; m_ovf_s = 0;
         pend_v = 0; m_target = 0; m_scnt = 0; m_ecnt = 0; m_sum = 0; m_sum_s = 0;
         m_wce = 0; pend_e = 0;
      end else begin
         bit acc;
         acc = in_valid && m_ready;
         if (pend_v) begin
            m_sum   = m_sum + pend_e;
            m_sum_s = m_sum_s + pend_e;
            if (m_sum > MAX48) begin m_sum = MAX48; m_ovf = 1; end
            if (m_sum_s > MAX18) begin m_sum_s = MAX18; m_ovf_s = 1; end
            if (pend_e > m_wce) m_wce = pend_e;
            if (pend_e != 0) m_ecnt++;
         end
         pend_v = acc;
         if (acc) pend_e = abs_err(in_a, in_b, in_approx);
         if (m_done) begin
            m_done = 0;
            m_busy = 0;
         end else if (!m_busy) begin
            if (start) begin
               m_scnt = 0; m_ecnt = 0; m_sum = 0; m_sum_s = 0; m_wce = 0;
               m_ovf = 0; m_ovf_s = 0;
               m_target = num_samples;
               m_busy = 1;
               if (num_samples == 0) m_done = 1;
               else m_ready = 1;
            end
         end else if (acc) begin
            m_scnt++;
            if (m_scnt == m_target) begin m_ready = 0; m_drain = 1; end
         end else if (m_drain) begin
            m_drain = 0;
            m_done = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (cmp_en) begin
         chk("in_ready", in_ready, m_ready);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("sample_cnt", sample_cnt, m_scnt);
         chk("err_cnt", err_cnt, m_ecnt);
         chk("err_sum", err_sum, m_sum);
         chk("wce", wce, m_wce);
         chk("ovf", ovf, m_ovf);
         chk("s_in_ready", s_in_ready, m_ready);
         chk("s_busy", s_busy, m_busy);
         chk("s_done", s_done, m_done);
         chk("s_sample_cnt", s_sample_cnt, m_scnt);
         chk("s_err_cnt", s_err_cnt, m_ecnt);
         chk("s_err_sum", s_err_sum, m_sum_s);
         chk("s_wce", s_wce, m_wce);
         chk("s_ovf", s_ovf, m_ovf_s);
      end
   end

   task automatic do_start(input logic [31:0] n);
      @(negedge clk);
      start = 1'b1;
      num_samples = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
      bit rdy;
      int n = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_approx = ap;
      do begin
         rdy = in_ready;
         @(negedge clk);
         n++;
      end while (!rdy && n < 50);
      if (!rdy) chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", done, 1);
   endtask

   task automatic rand_sample();
      logic [16:0] ex;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      ex = {1'b0, in_a} + {1'b0, in_b};
      case ($urandom_range(0, 3))
         0: in_approx = ex;
         1: in_approx = ex + 17'($urandom_range(0, 64)) - 17'd32;
         2: in_approx = 17'($urandom);
         default: in_approx = ex ^ (17'd1 << $urandom_range(0, 16));
      endcase
   endtask

   initial begin
      int d0, acc_n, cyc;
      logic [6:0] pat;
      bit saw_ready;

      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_sum", err_sum, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Exact results
      d0 = done_cnt;
      do_start(3);
      send(16'h1234, 16'h0001, 17'h01235);
      send(16'h0000, 16'h0000, 17'h00000);
      send(16'h8000, 16'h8000, 17'h10000);
      wait_done();
      chk("t1_err_sum", err_sum, 0);
      chk("t1_wce", wce, 0);
      chk("t1_err_cnt", err_cnt, 0);
      chk("t1_sample_cnt", sample_cnt, 3);
      repeat (3) @(negedge clk);
      chk("t1_done_pulses", done_cnt - d0, 1);

      // Worst case and both error directions
      do_start(2);
      send(16'hFFFF, 16'hFFFF, 17'h00000);
      send(16'h0000, 16'h0001, 17'h00041);
      wait_done();
      chk("t2_err_sum", err_sum, 131134);
      chk("t2_wce", wce, 17'h1FFFE);
      chk("t2_err_cnt", err_cnt, 2);
      repeat (2) @(negedge clk);

      // Gaps in in_valid
      do_start(4);
      pat = 7'b1011001;
      acc_n = 0;
      for (int i = 0; i < 7; i++) begin
         in_valid = pat[i];
         rand_sample();
         if (in_valid && in_ready) acc_n++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("t3_accepts", acc_n, 4);
      chk("t3_ready_low", in_ready, 0);
      chk("t3_done_early", done, 0);
      @(negedge clk);
      chk("t3_done", done, 1);
      chk("t3_sample_cnt", sample_cnt, 4);
      repeat (2) @(negedge clk);

      // Zero-length run
      saw_ready = 1'b0;
      do_start(0);
      chk("t4_done", done, 1);
      chk("t4_sample_cnt", sample_cnt, 0);
      chk("t4_err_sum", err_sum, 0);
      chk("t4_wce", wce, 0);
      for (int i = 0; i < 3; i++) begin
         if (in_ready) saw_ready = 1'b1;
         @(negedge clk);
      end
      chk("t4_ready_never", saw_ready, 0);

      // Saturation of the 18-bit accumulator
      do_start(3);
      repeat (3) send(16'hFFFF, 16'hFFFF, 17'h00000);
      wait_done();
      chk("t5_s_err_sum", s_err_sum, 18'h3FFFF);
      chk("t5_s_ovf", s_ovf, 1);
      chk("t5_s_wce", s_wce, 17'h1FFFE);
      chk("t5_err_sum", err_sum, 48'h5FFFA);
      chk("t5_ovf", ovf, 0);
      repeat (2) @(negedge clk);

      // Reset mid-run with a stage-1 entry in flight
      do_start(5);
      send(16'd1, 16'd2, 17'd0);
      send(16'd10, 16'd0, 17'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", in_ready, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_sample_cnt", sample_cnt, 0);
      chk("t6_rst_err_sum", err_sum, 0);
      chk("t6_rst_wce", wce, 0);
      chk("t6_rst_err_cnt", err_cnt, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      do_start(1);
      send(16'd7, 16'd0, 17'd2);
      wait_done();
      chk("t6_err_sum", err_sum, 5);
      chk("t6_err_cnt", err_cnt, 1);
      chk("t6_sample_cnt", sample_cnt, 1);
      chk("t6_wce", wce, 5);
      repeat (2) @(negedge clk);

      // Randomized runs
      for (int r = 0; r < 30; r++) begin
         do_start(32'($urandom_range(0, 8)));
         cyc = 0;
         while (!done && cyc < 300) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_sample();
            start = ($urandom_range(0, 9) == 0);
            num_samples = 32'($urandom_range(0, 8));
            @(negedge clk);
            cyc++;
         end
         start = 1'b0;
         in_valid = 1'b0;
         if (!done) chk("rand_done_timeout", done, 1);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
